// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and width default for the bit-serial adder
package serial_adder_pkg;

  // Operand/sum width used when the instantiating level does not override it
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: waiting for operands, rippling one bit per cycle, holding the result
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..n inclusive
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// rtl/serial_adder_fa_bit.sv - single-bit full-adder cell shared by every bit position
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit column
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder pass per cycle; SERIAL_ADDER_SUB_EN adds a subtract input
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_co;

  // Operand B and initial carry as captured; subtraction is A + ~B + 1
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : c_in;
  end
`else
  always_comb begin
    b_load = b;
    c_load = c_in;
  end
`endif

  // The one adder cell always looks at the current LSBs and the carry flop
  fa_bit u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB
  always_comb begin
    sum_next            = sum_r >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  // Controller and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sum_r <= sum_next;
          carry <= fa_co;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags are pure decodes of the state register
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    sum       = sum_r;
    c_out     = carry;
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder against an arithmetic model
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Reference: plain (W+1)-bit arithmetic; subtraction carries out when there is no borrow
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    end
    return r;
  endfunction

  // Drive one operation to completion; operands are scrambled right after capture
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                        input logic tsub, output logic [W-1:0] rs, output logic rc,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    a = ta; b = tb_v; c_in = tci;
`ifdef SERIAL_ADDER_SUB_EN
    sub = tsub;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = ~tsub;
`endif
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    rs = sum; rc = c_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (sum !== '0) $display("FAIL reset_sum got %h want 00", sum); else pass_cnt++;
    total_cnt++;
    if (c_out !== 1'b0) $display("FAIL reset_c_out got %b want 0", c_out); else pass_cnt++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic [W-1:0] va[3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [W-1:0] vb[3] = '{8'h33, 8'h01, 8'hFF};
    logic         vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es[3] = '{8'h8D, 8'h00, 8'hFF};
    logic         ec[3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, rs, rc, lat);
      total_cnt++;
      if (rs !== es[i]) $display("FAIL vec%0d_sum got %h want %h", i, rs, es[i]); else pass_cnt++;
      total_cnt++;
      if (rc !== ec[i]) $display("FAIL vec%0d_c_out got %b want %b", i, rc, ec[i]); else pass_cnt++;
      total_cnt++;
      if (lat !== W) $display("FAIL vec%0d_latency got %0d want %0d", i, lat, W); else pass_cnt++;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ta, tb_v, rs;
    logic         tci, rc;
    logic [W:0]   exp;
    int           lat;
    for (int i = 0; i < 16; i++) begin
      ta = W'($urandom); tb_v = W'($urandom); tci = 1'($urandom);
      exp = model(ta, tb_v, tci, 1'b0);
      run_op(ta, tb_v, tci, 1'b0, rs, rc, lat);
      total_cnt++;
      if ({rc, rs} !== exp || lat !== W)
        $display("FAIL rand%0d a=%h b=%h ci=%b got c=%b s=%h lat=%0d want c=%b s=%h lat=%0d",
                 i, ta, tb_v, tci, rc, rs, lat, exp[W], exp[W-1:0], W);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    int lat;
    bit ok;
    a = 8'h5A; b = 8'h33; c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    total_cnt++;
    if (lat !== W) $display("FAIL hold_latency got %0d want %0d", lat, W); else pass_cnt++;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      a = 8'h01; b = 8'h02; c_in = 1'b1;
      if (sum !== 8'h8D || c_out !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL hold_cycle%0d got s=%h c=%b ov=%b ir=%b want s=8d c=0 ov=1 ir=0",
                 i, sum, c_out, out_valid, in_ready);
        ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (!ok) $display("FAIL hold_stable got unstable want stable"); else pass_cnt++;
    total_cnt++;
    if (sum !== 8'h8D || out_valid !== 1'b1)
      $display("FAIL hold_end got s=%h ov=%b want s=8d ov=1", sum, out_valid);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL hold_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL hold_ignored got ir=%b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    bit           seen;
    a = 8'hAA; b = 8'h55; c_in = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (sum !== '0 || c_out !== 1'b0)
      $display("FAIL midrst_outputs got s=%h c=%b want s=00 c=0", sum, c_out);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midrst_flags got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL midrst_no_result got out_valid=1 want never"); else pass_cnt++;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, rs, rc, lat);
    total_cnt++;
    if (rs !== 8'h02 || rc !== 1'b0 || lat !== W)
      $display("FAIL midrst_after got s=%h c=%b lat=%0d want s=02 c=0 lat=%0d", rs, rc, lat, W);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ta, tb_v;
    logic         tci;
    logic [W:0]   exp;
    int           guard, lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ta = W'($urandom); tb_v = W'($urandom); tci = 1'($urandom);
      exp = model(ta, tb_v, tci, 1'b0);
      a = ta; b = tb_v; c_in = tci;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 200) begin
        @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 200) begin
        @(posedge clk); #1; lat++;
      end
      total_cnt++;
      if ({c_out, sum} !== exp || lat !== W)
        $display("FAIL b2b%0d got c=%b s=%h lat=%0d want c=%b s=%h lat=%0d",
                 i, c_out, sum, lat, exp[W], exp[W-1:0], W);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL b2b_end got ir=%b want 1", in_ready); else pass_cnt++;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [W-1:0] ta, tb_v, rs;
    logic         rc;
    logic [W:0]   exp;
    int           lat;
    run_op(8'h10, 8'h01, 1'b0, 1'b1, rs, rc, lat);
    total_cnt++;
    if (rs !== 8'h0F || rc !== 1'b1) $display("FAIL sub0 got c=%b s=%h want c=1 s=0f", rc, rs); else pass_cnt++;
    run_op(8'h01, 8'h02, 1'b0, 1'b1, rs, rc, lat);
    total_cnt++;
    if (rs !== 8'hFF || rc !== 1'b0) $display("FAIL sub1 got c=%b s=%h want c=0 s=ff", rc, rs); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      ta = W'($urandom); tb_v = W'($urandom);
      exp = model(ta, tb_v, 1'b0, 1'b1);
      run_op(ta, tb_v, 1'($urandom), 1'b1, rs, rc, lat);
      total_cnt++;
      if ({rc, rs} !== exp)
        $display("FAIL subrand%0d a=%h b=%h got c=%b s=%h want c=%b s=%h",
                 i, ta, tb_v, rc, rs, exp[W], exp[W-1:0]);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_vectors;
    test_random;
    test_hold;
    test_reset_mid;
    test_back_to_back;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  operands presented.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  addend A.
REQ-007 Port: b  input  WIDTH  addend B.
REQ-008 Port: c_in  input  1  carry into bit 0.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
REQ-012 Port: c_out  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-015 On an edge with in_valid && in_ready, the block SHALL capture a, b and c_in into internal shift registers and carry flop, clear the bit counter and enter SHIFT.
REQ-016 In SHIFT, each cycle SHALL add bit 0 of both shift registers plus the carry flop through one full-adder cell, shift the result bit into the MSB of the sum register, update the carry flop and right-shift both operand registers.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; the counter (width clog2(WIDTH+1)) SHALL move to DONE on the edge that processes bit WIDTH-1.
REQ-018 Latency: accept on edge k implies out_valid high from edge k+WIDTH.
REQ-019 In DONE, sum and c_out SHALL hold stable until out_valid && out_ready, on which edge the FSM SHALL return to IDLE.
REQ-020 in_valid SHALL be ignored in SHIFT and DONE; input changes after capture SHALL NOT affect the result.
REQ-021 With WIDTH == 1, SHIFT SHALL last one cycle and the rules above SHALL still hold.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, sum = 0, c_out = 0, out_valid = 0, in_ready = 1, counter = 0, carry flop = 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no result ever delivered.
REQ-024 After rst_n rises, the first accepted operation SHALL complete correctly.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN, when defined, SHALL add port "sub  input  1  subtract request", sampled with the operands.
REQ-026 With SERIAL_ADDER_SUB_EN defined and sub = 1 at capture, the block SHALL store ~b and set the carry flop to 1 (c_in ignored), giving sum = (a - b) mod 2^WIDTH and c_out = 1 when no borrow occurs.
REQ-027 Without SERIAL_ADDER_SUB_EN, the sub port and logic SHALL be absent and the behaviour SHALL be addition only.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the FSM state enum typedef and the default-width constant (8).
REQ-029 Sub-module fa_bit SHALL be the single combinational full-adder cell (a, b, ci -> s, co), instantiated once.

Verification
REQ-030 WIDTH=8, a=0x5A, b=0x33, c_in=0 -> after 8 SHIFT cycles sum=0x8D, c_out=0, out_valid=1.
REQ-031 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1 (wrap-around).
REQ-032 a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-033 out_ready held low for 5 cycles in DONE with a second in_valid pulse -> sum, c_out and out_valid stable, in_ready=0, second request ignored; out_ready=1 -> IDLE on the next edge.
REQ-034 rst_n pulsed low on SHIFT cycle 3 -> outputs zero asynchronously, in_ready=1, no out_valid; a following op with a=0x01, b=0x01 yields sum=0x02.
REQ-035 SERIAL_ADDER_SUB_EN defined: sub=1, a=0x10, b=0x01 -> sum=0x0F, c_out=1; sub=1, a=0x01, b=0x02 -> sum=0xFF, c_out=0.
